vga_timing: RTL

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock and feeds the pixel coordinates `x`/`y` consumed by the board renderer. Pixel rate is the system clock divided by two. The block drives the ADV7123-style DAC control pins and the monitor sync lines. It can optionally realign the sync signals with the renderer's registered RGB path.

---
 rtl/vga_timing.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// VGA raster timing: region FSMs on h/v counters stepped at clk/2, with registered sync/blank decode.
// Build option VGA_SYNC_DELAY_EN delays hsync/vsync/blank_n by SYNC_DELAY clk to line up with the RGB path.
module vga_timing #(
  parameter int HACTIVE    = 640,
  parameter int HFP        = 16,
  parameter int HSYNC      = 96,
  parameter int HBP        = 48,
  parameter int VACTIVE    = 480,
  parameter int VFP        = 10,
  parameter int VSYNC      = 2,
  parameter int VBP        = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [9:0] H_ACT_END = 10'(HACTIVE - 1);
  localparam logic [9:0] H_FP_END  = 10'(HACTIVE + HFP - 1);
  localparam logic [9:0] H_SY_END  = 10'(HACTIVE + HFP + HSYNC - 1);
  localparam logic [9:0] H_TOT_END = 10'(HTOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(VACTIVE - 1);
  localparam logic [9:0] V_FP_END  = 10'(VACTIVE + VFP - 1);
  localparam logic [9:0] V_SY_END  = 10'(VACTIVE + VFP + VSYNC - 1);
  localparam logic [9:0] V_TOT_END = 10'(VTOTAL - 1);

  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

  logic       phase_reg;
  logic [9:0] h_cnt_reg, h_cnt_next, v_cnt_reg, v_cnt_next;
  h_state_t   h_state_reg, h_state_next;
  v_state_t   v_state_reg, v_state_next;
  logic       h_wrap, v_wrap, tick;
  logic       hsync_reg, vsync_reg, blank_reg, frame_start_reg;

  assign tick   = phase_reg;
  assign h_wrap = tick && (h_cnt_reg == H_TOT_END);
  assign v_wrap = h_wrap && (v_cnt_reg == V_TOT_END);

  always_comb begin
    h_cnt_next   = h_cnt_reg;
    h_state_next = h_state_reg;
    if (tick) begin
      h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
      case (h_state_reg)
        H_ACTIVE: if (h_cnt_reg == H_ACT_END) h_state_next = H_FRONT;
        H_FRONT:  if (h_cnt_reg == H_FP_END)  h_state_next = H_SYNC;
        H_SYNC:   if (h_cnt_reg == H_SY_END)  h_state_next = H_BACK;
        default:  if (h_cnt_reg == H_TOT_END) h_state_next = H_ACTIVE;
      endcase
    end
  end

  // The vertical machine steps only on the tick that closes a line.
  always_comb begin
    v_cnt_next   = v_cnt_reg;
    v_state_next = v_state_reg;
    if (h_wrap) begin
      v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
      case (v_state_reg)
        V_ACTIVE: if (v_cnt_reg == V_ACT_END) v_state_next = V_FRONT;
        V_FRONT:  if (v_cnt_reg == V_FP_END)  v_state_next = V_SYNC;
        V_SYNC:   if (v_cnt_reg == V_SY_END)  v_state_next = V_BACK;
        default:  if (v_cnt_reg == V_TOT_END) v_state_next = V_ACTIVE;
      endcase
    end
  end

  // Decode from next-state values so the sync registers stay aligned with x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg       <= 1'b0;
      h_cnt_reg       <= 10'd0;
      v_cnt_reg       <= 10'd0;
      h_state_reg     <= H_ACTIVE;
      v_state_reg     <= V_ACTIVE;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      blank_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      phase_reg       <= ~phase_reg;
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      h_state_reg     <= h_state_next;
      v_state_reg     <= v_state_next;
      hsync_reg       <= (h_state_next != H_SYNC);
      vsync_reg       <= (v_state_next != V_SYNC);
      blank_reg       <= (h_state_next == H_ACTIVE) && (v_state_next == V_ACTIVE);
      frame_start_reg <= v_wrap;
    end
  end

  assign x           = h_cnt_reg;
  assign y           = v_cnt_reg;
  assign vga_clk     = phase_reg;
  assign sync_n      = 1'b0;
  assign frame_start = frame_start_reg;

`ifdef VGA_SYNC_DELAY_EN
  // Stage word is {hsync, vsync, blank_n}; blank_n resets low so no pixel shows before the pipe fills.
  logic [2:0] dly_reg [SYNC_DELAY];

  generate
    for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_dly
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_reg[gi] <= 3'b110;
        end else if (gi == 0) begin
          dly_reg[gi] <= {hsync_reg, vsync_reg, blank_reg};
        end else begin
          dly_reg[gi] <= dly_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign {hsync, vsync, blank_n} = dly_reg[SYNC_DELAY-1];
`else
  logic [31:0] unused_sync_delay;
  assign unused_sync_delay = 32'(SYNC_DELAY);

  assign hsync   = hsync_reg;
  assign vsync   = vsync_reg;
  assign blank_n = blank_reg;
`endif

endmodule
